integrator_diff_sat: RTL and testbench



---
 rtl/integrator_diff_sat.sv | 98 +++++++++
 tb/tb_integrator_diff_sat.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/integrator_diff_sat.sv
// integrator_diff_sat: saturating first difference y[n] = sat(x[n] - x[n-1]) of a signed running-sum stream.
// Latency 1 cycle from accept to out_valid; single-entry output register, 1 sample/cycle with out_ready high.
// Backpressure: in_ready = ~clr & (~out_valid | out_ready), held low in reset. Optional DIFF_SATCNT_EN adds sat_count.
module integrator_diff_sat #(
  parameter int WIDTH = 10
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic             sat_sticky
`ifdef DIFF_SATCNT_EN
  ,
  output logic [7:0]       sat_count
`endif
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev;
  logic [WIDTH:0]   diff;
  logic             accept;
  logic             sat_next;
  logic [WIDTH-1:0] data_next;

  assign out_valid = (state == FULL);
  // Ready is masked during reset so nothing is consumed while the block is held.
  assign in_ready  = system1000_rstn & ~clr & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;

  // Exact difference in WIDTH+1 bits, then clip to the WIDTH-bit signed range.
  always_comb begin
    diff      = {in_data[WIDTH-1], in_data} - {prev[WIDTH-1], prev};
    sat_next  = 1'b0;
    data_next = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      sat_next  = 1'b1;
      data_next = diff[WIDTH] ? MIN_NEG : MAX_POS;
    end
  end

  // Output register occupancy: fill on accept, drain on out_ready, hold otherwise.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL: begin
        if (accept)         state_next = FULL;
        else if (out_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register; reset and clr both discard any pending output.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn || clr) state <= EMPTY;
    else                          state <= state_next;
  end

  // History, output payload and sticky flag; payload only changes on accept.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      prev       <= '0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      sat_sticky <= 1'b0;
    end else if (clr) begin
      prev       <= '0;
      sat_sticky <= 1'b0;
    end else if (accept) begin
      prev       <= in_data;
      out_data   <= data_next;
      out_sat    <= sat_next;
      sat_sticky <= sat_sticky | sat_next;
    end
  end

`ifdef DIFF_SATCNT_EN
  // Clip event counter, saturating at 255.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn || clr)                    sat_count <= 8'd0;
    else if (accept && sat_next && sat_count != 8'hFF) sat_count <= sat_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_integrator_diff_sat.sv
// Directed bench for integrator_diff_sat: reset, basic differencing, saturation, backpressure, clr, reset mid-stream.
// Inputs driven 1 time unit after the rising edge; outputs checked at that same point after each edge.
// Expected values are hand-computed from the difference/saturation rule.
module tb_integrator_diff_sat;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             rstn;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;
  logic             sat_sticky;
`ifdef DIFF_SATCNT_EN
  logic [7:0]       sat_count;
`endif

  int tests  = 0;
  int failed = 0;

  integrator_diff_sat #(.WIDTH(WIDTH)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clr             (clr),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_sat         (out_sat),
    .sat_sticky      (sat_sticky)
`ifdef DIFF_SATCNT_EN
    ,
    .sat_count       (sat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int data, input logic sat);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, $signed(out_data), data);
    chk({tag, "_sat"}, out_sat, sat);
  endtask

  task automatic drive(input logic v, input int d);
    in_valid = v;
    in_data  = d[WIDTH-1:0];
  endtask

  task automatic pulse_clr();
    clr      = 1'b1;
    in_valid = 1'b0;
    cyc();
    clr      = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    cyc();
    cyc();
    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sticky", sat_sticky, 0);
`ifdef DIFF_SATCNT_EN
    chk("rst_count", sat_count, 0);
`endif
    rstn = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Basic: 5, 12, 12, -3 -> 5, 7, 0, -15
    drive(1, 5);   cyc(); chk_out("b0", 5, 0);
    drive(1, 12);  cyc(); chk_out("b1", 7, 0);
    drive(1, 12);  cyc(); chk_out("b2", 0, 0);
    drive(1, -3);  cyc(); chk_out("b3", -15, 0);
    drive(0, 0);   cyc();
    chk("b_drain", out_valid, 0);
    chk("b_sticky", sat_sticky, 0);

    // Saturation negative: 300, -300 -> 300, -512 clipped
    pulse_clr();
    drive(1, 300);  cyc(); chk_out("s0", 300, 0);
    chk("s0_sticky", sat_sticky, 0);
    drive(1, -300); cyc(); chk_out("s1", -512, 1);
    chk("s1_sticky", sat_sticky, 1);
    drive(0, 0);    cyc();
`ifdef DIFF_SATCNT_EN
    chk("s1_count", sat_count, 1);
`endif

    // Saturation positive: -512, 511 -> -512, 511 clipped (d = 1023)
    pulse_clr();
    chk("clr_sticky", sat_sticky, 0);
    drive(1, -512); cyc(); chk_out("s2", -512, 0);
    drive(1, 511);  cyc(); chk_out("s3", 511, 1);
    chk("s3_sticky", sat_sticky, 1);
    drive(0, 0);    cyc();
`ifdef DIFF_SATCNT_EN
    chk("s3_count", sat_count, 1);
`endif

    // Backpressure: 5 held while out_ready=0, then 20 and 30 -> 15, 10
    pulse_clr();
    drive(1, 5); cyc(); chk_out("p0", 5, 0);
    out_ready = 1'b0; drive(1, 20);
    #1;
    chk("p_stall_ready", in_ready, 0);
    cyc(); chk_out("p_hold1", 5, 0);
    cyc(); chk_out("p_hold2", 5, 0);
    chk("p_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("p_release_ready", in_ready, 1);
    cyc(); chk_out("p1", 15, 0);
    drive(1, 30); cyc(); chk_out("p2", 10, 0);
    drive(0, 0);  cyc();
    chk("p_drain", out_valid, 0);

    // clr mid-stream: prev=100 with FULL output, clr while presenting 50
    pulse_clr();
    drive(1, -512); cyc(); chk_out("c0", -512, 0);
    drive(1, 100);  cyc(); chk_out("c1", 511, 1);
    out_ready = 1'b0; drive(1, 50); clr = 1'b1;
    #1;
    chk("c_clr_ready", in_ready, 0);
    cyc();
    clr = 1'b0; out_ready = 1'b1;
    chk("c_clr_valid", out_valid, 0);
    chk("c_clr_sticky", sat_sticky, 0);
    cyc(); chk_out("c2", 50, 0);
    chk("c2_sticky", sat_sticky, 0);

    // Reset mid-operation while FULL, then 7 -> 7
    out_ready = 1'b0; drive(0, 0);
    rstn = 1'b0;
    cyc();
    chk("r_valid", out_valid, 0);
    chk("r_data", $signed(out_data), 0);
    rstn = 1'b1; out_ready = 1'b1;
    drive(1, 7); cyc(); chk_out("r0", 7, 0);
    drive(0, 0); cyc();

`ifdef DIFF_SATCNT_EN
    // Counter saturation: +511/-511 alternating, 299 clips -> 255
    pulse_clr();
    for (int i = 0; i < 300; i++) begin
      drive(1, (i % 2 == 0) ? 511 : -511);
      cyc();
    end
    drive(0, 0); cyc();
    chk("cnt_sat", sat_count, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
